fetch_sequencer: RTL and testbench

Next-PC controller for the instruction-fetch stage. Owns the program counter and a hardware return-address stack (RAS), and arbitrates the decode-stage control signals (SIG_Jump, SIG_RET, SIG_BNE, SIG_BEQ, SIG_CALL_RS1, SIG_Call) into one PC source per cycle. It also squashes the wrong-path instruction after every redirect and halts fetch on RAS misuse. It drives the instruction-memory address and PC4 into the IF/ID register.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_sequencer_if.sv | 34 +++
 rtl/ras_stack.sv | 51 +++++
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch next-PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ      = 3'd0,
    SEL_BRANCH   = 3'd1,
    SEL_JUMP     = 3'd2,
    SEL_CALL     = 3'd3,
    SEL_CALL_RS1 = 3'd4,
    SEL_RET      = 3'd5,
    SEL_HOLD     = 3'd7
  } pc_sel_e;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] next_seq(input logic [31:0] pc_in);
    return pc_in + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode-side control/target bundle and fetch-side PC outputs of the sequencer.
interface fetch_sequencer_if;
  logic        stall;
  logic        SIG_Jump;
  logic        SIG_RET;
  logic        SIG_BNE;
  logic        SIG_BEQ;
  logic        SIG_CALL_RS1;
  logic        SIG_Call;
  logic        SIG_EQ;
  logic [31:0] jumpAddress;
  logic [31:0] branchAddress;
  logic [31:0] callRs1Address;
  logic [31:0] decodePC4;
  logic [31:0] pc;
  logic [31:0] PC4;
  logic [2:0]  pc_sel;
  logic        flush;
  logic        halted;
  logic        ras_overflow;
  logic        ras_underflow;

  modport master (
    output stall, SIG_Jump, SIG_RET, SIG_BNE, SIG_BEQ, SIG_CALL_RS1, SIG_Call, SIG_EQ,
    output jumpAddress, branchAddress, callRs1Address, decodePC4,
    input  pc, PC4, pc_sel, flush, halted, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, SIG_Jump, SIG_RET, SIG_BNE, SIG_BEQ, SIG_CALL_RS1, SIG_Call, SIG_EQ,
    input  jumpAddress, branchAddress, callRs1Address, decodePC4,
    output pc, PC4, pc_sel, flush, halted, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/ras_stack.sv
// Return-address LIFO; top entry is readable combinationally at index count-1.
module ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] data,
  output logic [31:0] top,
  output logic        full,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [31:0]   entries_r [DEPTH];
  logic [PW:0]   count_r;
  logic [PW-1:0] wr_idx_s;
  logic [PW-1:0] top_idx_s;

  // Count wraps into the index width, so a full stack still points its top at DEPTH-1.
  assign wr_idx_s  = count_r[PW-1:0];
  assign top_idx_s = wr_idx_s - IDX_ONE;
  assign top       = entries_r[top_idx_s];
  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == '0);

  // Occupancy counter; guarded so it never leaves 0..DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (push && !full) begin
      count_r <= count_r + CNT_ONE;
    end else if (pop && !empty) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries_r[wr_idx_s] <= data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC controller: redirect priority, wrong-path squash and RAS-misuse halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   fif
);
  fetch_state_e state_r, state_s;
  pc_sel_e      sel_s;
  logic [31:0]  pc_r, pc_next_s;
  logic         flush_s;
  logic         push_s, pop_s;
  logic         ovf_set_s, unf_set_s;
  logic         ovf_r, unf_r;
  logic [31:0]  ras_top_s;
  logic         ras_full_s, ras_empty_s;

  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .data  (fif.decodePC4),
    .top   (ras_top_s),
    .full  (ras_full_s),
    .empty (ras_empty_s)
  );

  // Redirect resolution and next-state logic; defaults describe a held cycle.
  always_comb begin
    state_s   = state_r;
    pc_next_s = pc_r;
    sel_s     = SEL_HOLD;
    flush_s   = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case (state_r)
      ST_HALT: begin
        flush_s = 1'b1;
      end
      ST_BUBBLE: begin
        if (fif.stall) begin
          sel_s = SEL_HOLD;
        end else begin
          sel_s     = SEL_SEQ;
          pc_next_s = next_seq(pc_r);
          state_s   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fif.stall) begin
          sel_s = SEL_HOLD;
        end else begin
          if (fif.SIG_RET) begin
            if (ras_empty_s) begin
              unf_set_s = 1'b1;
            end else begin
              pop_s     = 1'b1;
              sel_s     = SEL_RET;
              pc_next_s = ras_top_s;
            end
          end else if (fif.SIG_CALL_RS1) begin
            if (ras_full_s) begin
              ovf_set_s = 1'b1;
            end else begin
              push_s    = 1'b1;
              sel_s     = SEL_CALL_RS1;
              pc_next_s = fif.callRs1Address;
            end
          end else if (fif.SIG_Call) begin
            if (ras_full_s) begin
              ovf_set_s = 1'b1;
            end else begin
              push_s    = 1'b1;
              sel_s     = SEL_CALL;
              pc_next_s = fif.jumpAddress;
            end
          end else if (fif.SIG_Jump) begin
            sel_s     = SEL_JUMP;
            pc_next_s = fif.jumpAddress;
          end else if ((fif.SIG_BEQ && fif.SIG_EQ) || (fif.SIG_BNE && !fif.SIG_EQ)) begin
            sel_s     = SEL_BRANCH;
            pc_next_s = fif.branchAddress;
          end else begin
            sel_s     = SEL_SEQ;
            pc_next_s = next_seq(pc_r);
          end

          // A RAS error holds pc (sel stays HOLD) and squashes what is in fetch.
          if (ovf_set_s || unf_set_s) begin
            state_s = ST_HALT;
            flush_s = 1'b1;
          end else if (sel_s != SEL_SEQ) begin
            state_s = ST_BUBBLE;
            flush_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      default: begin
        state_s = ST_HALT;
        flush_s = 1'b1;
      end
    endcase
  end

  // PC, FSM state and sticky RAS error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_next_s;
      ovf_r   <= ovf_r | ovf_set_s;
      unf_r   <= unf_r | unf_set_s;
    end
  end

  assign fif.pc            = pc_r;
  assign fif.PC4           = next_seq(pc_r);
  assign fif.pc_sel        = sel_s;
  assign fif.flush         = flush_s;
  assign fif.halted        = (state_r == ST_HALT);
  assign fif.ras_overflow  = ovf_r;
  assign fif.ras_underflow = unf_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a cycle-level reference model and literal checks.
module tb_fetch_sequencer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_sequencer_if fif ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .RAS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  // Reference state: what the architectural behaviour says pc/RAS/flags must be.
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  bit          m_skip, m_halt, m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fif.stall = 1'b0;  fif.SIG_Jump = 1'b0; fif.SIG_RET = 1'b0;  fif.SIG_BNE = 1'b0;
    fif.SIG_BEQ = 1'b0; fif.SIG_CALL_RS1 = 1'b0; fif.SIG_Call = 1'b0; fif.SIG_EQ = 1'b0;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin : model_proc
    logic [2:0]  e_sel;
    logic        e_flush;
    logic [31:0] npc;
    bit          redirect, err;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_pc = 32'h0; m_ras.delete(); m_skip = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
        chk ("m_rst_pc", fif.pc, 32'h0);
        chk1("m_rst_halted", fif.halted, 1'b0);
        chk1("m_rst_ovf", fif.ras_overflow, 1'b0);
        chk1("m_rst_unf", fif.ras_underflow, 1'b0);
      end else begin
        chk ("m_pc", fif.pc, m_pc);
        chk ("m_pc4", fif.PC4, m_pc + 32'd4);
        chk1("m_halted", fif.halted, m_halt);
        chk1("m_ovf", fif.ras_overflow, m_ovf);
        chk1("m_unf", fif.ras_underflow, m_unf);
        e_sel = 3'd7; e_flush = 1'b0; npc = m_pc; redirect = 0; err = 0;
        if (m_halt) begin
          e_flush = 1'b1;
        end else if (fif.stall) begin
          e_sel = 3'd7;
        end else if (m_skip) begin
          e_sel = 3'd0; npc = m_pc + 32'd4; m_skip = 0;
        end else begin
          if (fif.SIG_RET) begin
            if (m_ras.size() == 0) begin err = 1; m_unf = 1; end
            else begin npc = m_ras.pop_back(); e_sel = 3'd5; redirect = 1; end
          end else if (fif.SIG_CALL_RS1) begin
            if (m_ras.size() == DEPTH) begin err = 1; m_ovf = 1; end
            else begin m_ras.push_back(fif.decodePC4); npc = fif.callRs1Address; e_sel = 3'd4; redirect = 1; end
          end else if (fif.SIG_Call) begin
            if (m_ras.size() == DEPTH) begin err = 1; m_ovf = 1; end
            else begin m_ras.push_back(fif.decodePC4); npc = fif.jumpAddress; e_sel = 3'd3; redirect = 1; end
          end else if (fif.SIG_Jump) begin
            npc = fif.jumpAddress; e_sel = 3'd2; redirect = 1;
          end else if ((fif.SIG_BEQ && fif.SIG_EQ) || (fif.SIG_BNE && !fif.SIG_EQ)) begin
            npc = fif.branchAddress; e_sel = 3'd1; redirect = 1;
          end else begin
            npc = m_pc + 32'd4; e_sel = 3'd0;
          end
          if (err) begin m_halt = 1; e_flush = 1'b1; end
          if (redirect) begin m_skip = 1; e_flush = 1'b1; end
        end
        chk ("m_pc_sel", {29'd0, fif.pc_sel}, {29'd0, e_sel});
        chk1("m_flush", fif.flush, e_flush);
        m_pc = npc;
      end
    end
  end

  initial begin : stim
    logic [31:0] tgt;
    reset = 1'b0;
    idle();
    fif.jumpAddress = 32'h0; fif.branchAddress = 32'h0;
    fif.callRs1Address = 32'h0; fif.decodePC4 = 32'h0;
    repeat (2) tick();
    chk("reset_pc", fif.pc, 32'h0);
    reset = 1'b1;
    tick(); chk("seq_pc4", fif.pc, 32'h4);
    tick(); chk("seq_pc8", fif.pc, 32'h8);
    tick(); chk("seq_pc12", fif.pc, 32'hC);

    // Call then RET two cycles later
    fif.SIG_Call = 1'b1; fif.jumpAddress = 32'h3333_3333; fif.decodePC4 = 32'h10;
    #1 chk1("call_flush", fif.flush, 1'b1);
    chk("call_sel", {29'd0, fif.pc_sel}, 32'd3);
    tick(); idle(); chk("call_target", fif.pc, 32'h3333_3333);
    tick(); chk("call_bubble_seq", fif.pc, 32'h3333_3337);
    fif.SIG_RET = 1'b1;
    #1 chk1("ret_flush", fif.flush, 1'b1);
    tick(); idle(); chk("ret_target", fif.pc, 32'h10);
    tick(); chk("ret_bubble_seq", fif.pc, 32'h14);

    // Branches, and a Jump ignored in the bubble
    fif.SIG_BEQ = 1'b1; fif.SIG_EQ = 1'b0; fif.branchAddress = 32'h2222_2222;
    #1 chk("beq_nt_sel", {29'd0, fif.pc_sel}, 32'd0);
    tick(); chk("beq_nt_pc", fif.pc, 32'h18);
    fif.SIG_BEQ = 1'b0; fif.SIG_BNE = 1'b1;
    tick(); idle(); chk("bne_t_pc", fif.pc, 32'h2222_2222);
    fif.SIG_Jump = 1'b1; fif.jumpAddress = 32'h4444_4444;
    #1 chk1("bubble_jump_flush", fif.flush, 1'b0);
    tick(); idle(); chk("bubble_jump_ignored", fif.pc, 32'h2222_2226);

    // Stall held over a Jump for 3 cycles
    fif.SIG_Jump = 1'b1; fif.jumpAddress = 32'h50; fif.stall = 1'b1;
    repeat (3) begin
      #1 chk("stall_sel", {29'd0, fif.pc_sel}, 32'd7);
      tick(); chk("stall_pc", fif.pc, 32'h2222_2226);
    end
    fif.stall = 1'b0;
    #1 chk("jump_sel", {29'd0, fif.pc_sel}, 32'd2);
    tick(); idle(); chk("jump_after_stall", fif.pc, 32'h50);
    tick(); chk("jump_bubble_seq", fif.pc, 32'h54);

    // PC wrap
    fif.SIG_Jump = 1'b1; fif.jumpAddress = 32'hFFFF_FFF8;
    tick(); idle(); chk("wrap_target", fif.pc, 32'hFFFF_FFF8);
    tick(); chk("wrap_top", fif.pc, 32'hFFFF_FFFC); chk("wrap_pc4", fif.PC4, 32'h0);
    tick(); chk("wrap_zero", fif.pc, 32'h0);

    // LIFO order and CALL_RS1 priority over Call
    fif.SIG_Call = 1'b1; fif.jumpAddress = 32'h100; fif.decodePC4 = 32'hA0;
    tick(); idle(); tick();
    fif.SIG_Call = 1'b1; fif.jumpAddress = 32'h200; fif.decodePC4 = 32'hB0;
    tick(); idle(); tick();
    fif.SIG_RET = 1'b1;
    tick(); idle(); chk("lifo_first", fif.pc, 32'hB0); tick();
    fif.SIG_RET = 1'b1;
    tick(); idle(); chk("lifo_second", fif.pc, 32'hA0); tick();
    fif.SIG_CALL_RS1 = 1'b1; fif.SIG_Call = 1'b1;
    fif.callRs1Address = 32'h300; fif.jumpAddress = 32'h400; fif.decodePC4 = 32'hC0;
    #1 chk("rs1_sel", {29'd0, fif.pc_sel}, 32'd4);
    tick(); idle(); chk("rs1_target", fif.pc, 32'h300); tick();
    fif.SIG_RET = 1'b1;
    tick(); idle(); chk("rs1_ret", fif.pc, 32'hC0); tick();

    // Underflow: RET beats CALL_RS1 on an empty stack
    fif.SIG_RET = 1'b1; fif.SIG_CALL_RS1 = 1'b1; fif.callRs1Address = 32'h60;
    tick(); idle();
    chk("unf_pc", fif.pc, 32'hC4);
    chk1("unf_flag", fif.ras_underflow, 1'b1);
    chk1("unf_halted", fif.halted, 1'b1);
    fif.SIG_Jump = 1'b1; fif.jumpAddress = 32'h70;
    repeat (2) begin
      #1 chk1("halt_flush", fif.flush, 1'b1);
      tick(); chk("halt_pc", fif.pc, 32'hC4);
    end
    idle();
    reset = 1'b0;
    #1 chk("unf_reset_pc", fif.pc, 32'h0);
    chk1("unf_reset_flag", fif.ras_underflow, 1'b0);
    tick(); reset = 1'b1;

    // Overflow after DEPTH successful calls
    for (int i = 0; i <= DEPTH; i++) begin
      tgt = 32'h1000 + 32'(i) * 32'h100;
      fif.SIG_Call = 1'b1; fif.jumpAddress = tgt; fif.decodePC4 = 32'h2000 + 32'(i) * 32'h4;
      tick(); idle();
      if (i < DEPTH) begin
        chk("ovf_seq_target", fif.pc, tgt);
        tick();
      end
    end
    chk("ovf_pc", fif.pc, 32'h1704);
    chk1("ovf_flag", fif.ras_overflow, 1'b1);
    chk1("ovf_halted", fif.halted, 1'b1);
    chk1("ovf_unf_clear", fif.ras_underflow, 1'b0);
    reset = 1'b0;
    #1 chk1("ovf_reset_flag", fif.ras_overflow, 1'b0);
    chk1("ovf_reset_halted", fif.halted, 1'b0);
    tick(); reset = 1'b1;

    // Reset asserted in the middle of a Call redirect
    tick(); tick();
    fif.SIG_Call = 1'b1; fif.jumpAddress = 32'h500; fif.decodePC4 = 32'h600;
    #2 reset = 1'b0;
    #1 chk("mid_reset_pc", fif.pc, 32'h0);
    tick(); idle(); reset = 1'b1;
    fif.SIG_RET = 1'b1;
    tick(); idle();
    chk("mid_reset_ret_pc", fif.pc, 32'h0);
    chk1("mid_reset_ras_empty", fif.ras_underflow, 1'b1);

    reset = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
